seven_seg_scan_driver: RTL and testbench

//   Time-multiplexed driver for a common-anode N-digit seven-segment display.

---
 rtl/seg7_pkg.sv | 20 ++
 rtl/hex_to_seg7.sv | 11 +
 rtl/seven_seg_scan_driver.sv | 102 ++++++++++
 tb/tb_seven_seg_scan_driver.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared segment definitions for the seven-segment scan driver.
// Segment order is {g,f,e,d,c,b,a}, active-low.
package seg7_pkg;

    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG_OFF = 7'h7F;
    localparam int MAX_DIGITS = 32;

    localparam seg7_t HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Callers slice the low DIGITS bits of the result.
    function automatic logic [MAX_DIGITS-1:0] onehot_n(input logic [4:0] idx);
        return ~(MAX_DIGITS'(1) << idx);
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output seg7_t      seg
);

    assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver with double-buffered
// display data and per-slot PWM brightness.
module seven_seg_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 100000,
    parameter int DIM_BITS = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_en,
    input  logic [DIGITS-1:0]     blank,
    input  logic                  load,
    input  logic [DIM_BITS-1:0]   brightness,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic                  frame_done
);

    localparam int CW = $clog2(PRESCALE);
    localparam int TW = CW + 1;
    localparam int IW = $clog2(DIGITS);
    localparam int PW = DIM_BITS + TW + 1;
    localparam logic [CW-1:0] PRES_LAST = CW'(PRESCALE - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

    logic [CW-1:0]         pres_cnt;
    logic [IW-1:0]         idx;
    logic [TW-1:0]         thr_q;
    logic [4*DIGITS-1:0]   pend_value, act_value;
    logic [DIGITS-1:0]     pend_dp, act_dp;
    logic [DIGITS-1:0]     pend_blank, act_blank;

    logic                  slot_end;
    logic                  frame_end;
    logic [PW-1:0]         thr_prod;
    logic [TW-1:0]         thr_next;
    logic                  digit_on;
    logic [MAX_DIGITS-1:0] oh_full;
    logic [3:0]            nibble;
    seg7_t                 seg_dec;

    assign slot_end  = (pres_cnt == PRES_LAST);
    assign frame_end = slot_end && (idx == IDX_LAST);
    assign thr_prod  = (PW'(brightness) + PW'(1)) * PW'(PRESCALE);
    assign thr_next  = TW'(thr_prod >> DIM_BITS);
    // pres_cnt == 0 is the ghosting guard cycle; thr_q is refreshed on that same cycle.
    assign digit_on  = (pres_cnt != '0) && ({1'b0, pres_cnt} < thr_q) && !act_blank[idx];
    assign oh_full   = onehot_n(5'(idx));
    assign nibble    = act_value[4*idx +: 4];
    assign frame_done = frame_end;

    hex_to_seg7 u_dec (
        .nibble (nibble),
        .seg    (seg_dec)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            pres_cnt   <= '0;
            idx        <= '0;
            thr_q      <= '0;
            pend_value <= '0;
            pend_dp    <= '0;
            pend_blank <= '0;
            act_value  <= '0;
            act_dp     <= '0;
            act_blank  <= '0;
            an         <= '1;
            seg        <= SEG_OFF;
            dp         <= 1'b1;
        end else begin
            pres_cnt <= slot_end ? '0 : pres_cnt + CW'(1);
            if (slot_end)
                idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);

            if (load) begin
                pend_value <= value;
                pend_dp    <= dp_en;
                pend_blank <= blank;
            end

            // A load on the boundary edge bypasses pending so it is not lost for a frame.
            if (frame_end) begin
                act_value <= load ? value : pend_value;
                act_dp    <= load ? dp_en : pend_dp;
                act_blank <= load ? blank : pend_blank;
            end

            if (pres_cnt == '0)
                thr_q <= thr_next;

            an  <= digit_on ? oh_full[DIGITS-1:0] : '1;
            seg <= seg_dec;
            dp  <= ~act_dp[idx];
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Self-checking bench for seven_seg_scan_driver: reference-model scoreboard,
// vector table of whole-frame expectations, and hand-written corner sequences.
module tb_seven_seg_scan_driver;

    localparam int D  = 4;
    localparam int P  = 8;
    localparam int DB = 3;

    logic        clock = 1'b0;
    logic        reset;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_en;
    logic [3:0]  blank;
    logic [2:0]  brightness;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    always #5 clock = ~clock;

    seven_seg_scan_driver #(.DIGITS(D), .PRESCALE(P), .DIM_BITS(DB)) dut (
        .clock      (clock),
        .reset      (reset),
        .value      (value),
        .dp_en      (dp_en),
        .blank      (blank),
        .load       (load),
        .brightness (brightness),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: position in the frame as a plain cycle count.
    localparam logic [6:0] HEX_REF [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    int          n;
    int          m_pres, m_dig, m_thr;
    logic [15:0] m_pv, m_av;
    logic [3:0]  m_pd, m_ad, m_pb, m_ab;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic [3:0]  m_nib;

    always @(posedge clock) begin
        if (reset) begin
            n = 0; m_thr = 0;
            m_pv = '0; m_av = '0; m_pd = '0; m_ad = '0; m_pb = '0; m_ab = '0;
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
        end else begin
            m_pres = n % P;
            m_dig  = n / P;
            m_nib  = m_av[4*m_dig +: 4];
            e_an   = (m_pres != 0 && m_pres < m_thr && !m_ab[m_dig]) ? ~(4'b0001 << m_dig) : 4'hF;
            e_seg  = HEX_REF[m_nib];
            e_dp   = ~m_ad[m_dig];
            if (m_pres == 0) m_thr = ((int'(brightness) + 1) * P) >> DB;
            if (load) begin m_pv = value; m_pd = dp_en; m_pb = blank; end
            if (n == P*D - 1) begin m_av = m_pv; m_ad = m_pd; m_ab = m_pb; end
            n = (n + 1) % (P*D);
        end
    end

    bit sb_en = 1'b0;
    always @(negedge clock) begin
        if (sb_en)
            check("scan", {an, seg, dp, frame_done}, {e_an, e_seg, e_dp, (n == P*D - 1)});
    end

    task automatic wait_frame();
        int k = 0;
        do begin @(negedge clock); k++; end while (!frame_done && k < 100);
        if (!frame_done) begin
            checks++; failures++;
            $display("FAIL frame_timeout actual=0 required=1");
        end
    endtask

    int         cap_on [4];
    logic [6:0] cap_seg [4];
    logic [3:0] cap_dp;

    // Captures the frame following the next boundary: output j reflects slot j/P, cycle j%P.
    task automatic capture_frame();
        for (int d = 0; d < D; d++) begin cap_on[d] = 0; cap_seg[d] = 'x; end
        cap_dp = 'x;
        wait_frame();
        @(negedge clock);
        for (int j = 0; j < P*D; j++) begin
            @(negedge clock);
            if (an[j/P] == 1'b0) cap_on[j/P]++;
            if (j % P == 1) begin cap_seg[j/P] = seg; cap_dp[j/P] = dp; end
        end
    endtask

    typedef struct {
        logic [15:0]      value;
        logic [3:0]       dp_en;
        logic [3:0]       blank;
        logic [2:0]       bright;
        logic [3:0][6:0]  seg;
        logic [3:0][3:0]  on;
        logic [3:0]       dp;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int k;
        int on0, on1;

        vecs[0] = '{16'h3210, 4'b0000, 4'b0000, 3'd7, {7'h30, 7'h24, 7'h79, 7'h40}, {4'd7, 4'd7, 4'd7, 4'd7}, 4'b1111};
        vecs[1] = '{16'hFFFF, 4'b0000, 4'b0000, 3'd7, {7'h0E, 7'h0E, 7'h0E, 7'h0E}, {4'd7, 4'd7, 4'd7, 4'd7}, 4'b1111};
        vecs[2] = '{16'h7654, 4'b0001, 4'b0100, 3'd7, {7'h78, 7'h02, 7'h12, 7'h19}, {4'd7, 4'd0, 4'd7, 4'd7}, 4'b1110};
        vecs[3] = '{16'hBA98, 4'b1010, 4'b0000, 3'd1, {7'h03, 7'h08, 7'h10, 7'h00}, {4'd1, 4'd1, 4'd1, 4'd1}, 4'b0101};
        vecs[4] = '{16'hFEDC, 4'b0000, 4'b1001, 3'd3, {7'h0E, 7'h06, 7'h21, 7'h46}, {4'd0, 4'd3, 4'd3, 4'd0}, 4'b1111};

        reset = 1'b1; load = 1'b0; value = '0; dp_en = '0; blank = '0; brightness = 3'd7;

        // Reset state and first-digit latency.
        repeat (3) @(negedge clock);
        sb_en = 1'b1;
        check("rst_an", an, 4'hF);
        check("rst_seg", seg, 7'h7F);
        check("rst_dp", dp, 1'b1);
        check("rst_fd", frame_done, 1'b0);
        reset = 1'b0;
        k = 0;
        do begin @(negedge clock); k++; end while (an !== 4'b1110 && k < 10);
        check("first_digit_latency", k, 2);

        // Whole-frame vector table.
        for (int i = 0; i < 5; i++) begin
            value = vecs[i].value; dp_en = vecs[i].dp_en; blank = vecs[i].blank;
            brightness = vecs[i].bright; load = 1'b1;
            @(negedge clock);
            load = 1'b0;
            capture_frame();
            for (int d = 0; d < D; d++) begin
                check($sformatf("vec%0d_seg%0d", i, d), cap_seg[d], vecs[i].seg[d]);
                check($sformatf("vec%0d_on%0d", i, d), cap_on[d], vecs[i].on[d]);
            end
            check($sformatf("vec%0d_dp", i), cap_dp, vecs[i].dp);
        end

        // Double buffer: load mid-frame must not tear the current frame.
        value = 16'h3210; dp_en = '0; blank = '0; brightness = 3'd7; load = 1'b1;
        @(negedge clock);
        load = 1'b0;
        wait_frame();
        wait_frame();
        repeat (11) @(negedge clock);
        value = 16'hFFFF; load = 1'b1;
        @(negedge clock);
        load = 1'b0;
        repeat (8) @(negedge clock);
        check("db_keep_d2", seg, 7'h24);
        repeat (8) @(negedge clock);
        check("db_keep_d3", seg, 7'h30);
        repeat (8) @(negedge clock);
        check("db_new_d0", seg, 7'h0E);
        wait_frame();
        k = 0;
        do begin @(negedge clock); k++; end while (!frame_done && k < 64);
        check("frame_period", k, 32);
        @(negedge clock);
        check("frame_pulse_width", frame_done, 1'b0);

        // Brightness change mid-slot applies from the next slot.
        brightness = 3'd1;
        wait_frame();
        on0 = 0; on1 = 0;
        for (int i = 0; i < 2*P + 2; i++) begin
            @(negedge clock);
            if (i == 3) brightness = 3'd7;
            if (an[0] == 1'b0) on0++;
            if (an[1] == 1'b0) on1++;
        end
        check("dim_slot0_on", on0, 1);
        check("dim_slot1_on", on1, 7);

        // Reset at idx=2, pres_cnt=5.
        wait_frame();
        repeat (22) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("midrst_an", an, 4'hF);
        check("midrst_seg", seg, 7'h7F);
        check("midrst_dp", dp, 1'b1);
        check("midrst_fd", frame_done, 1'b0);
        reset = 1'b0;
        @(negedge clock);
        check("midrst_guard", an, 4'hF);
        @(negedge clock);
        check("midrst_restart_an", an, 4'b1110);
        check("midrst_cleared_seg", seg, 7'h40);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 6*P*D; i++) begin
            @(negedge clock);
            value = 16'($urandom);
            dp_en = 4'($urandom);
            blank = 4'($urandom);
            load  = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 7) == 0) brightness = 3'($urandom);
        end
        @(negedge clock);
        load = 1'b0;
        repeat (P*D) @(negedge clock);

        sb_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
